// File: rtl/array_writer.sv
// Fills a DEPTH-entry array from a valid/ready stream and exposes a registered read port (1-cycle latency).
// Backpressure: in_ready is high only in FILL; start is ignored outside IDLE.
module array_writer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [31:0]      rd_index,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W:0]   r_count;
    logic             r_done;
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] r_arr [DEPTH];

    logic             w_xfer;
    logic             w_rd_in_range;
    logic [IDX_W-1:0] w_rd_idx;

    assign in_ready      = (r_state == S_FILL);
    assign busy          = (r_state != S_IDLE);
    assign w_xfer        = in_valid && in_ready;
    // Full 32-bit compare so out-of-range indices never alias onto a real entry.
    assign w_rd_in_range = (rd_index < 32'(DEPTH));
    assign w_rd_idx      = rd_index[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_arr[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_rd_data <= w_rd_in_range ? r_arr[w_rd_idx] : '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_FILL;
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                    end
                end
                S_FILL: begin
                    if (w_xfer) begin
                        r_arr[r_wr_ptr] <= in_data;
                        r_wr_ptr        <= r_wr_ptr + 1'b1;
                        r_count         <= r_count + 1'b1;
                        if (r_wr_ptr == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign done    = r_done;
    assign count   = r_count;

endmodule
